// File: rtl/ac_sweep_dds_if.sv
// Control, configuration and sample-stream signals of the stepped-frequency sweep DDS.
// The stimulus/control side takes the master modport; the generator takes slave.
interface ac_sweep_dds_if #(
    parameter int PHASE_W = 24,
    parameter int AMP_W   = 12,
    parameter int CNT_W   = 16
);
    logic                       start;
    logic                       abort;
    logic [PHASE_W-1:0]         f_start;
    logic [PHASE_W-1:0]         f_step;
    logic [CNT_W-1:0]           n_points;
    logic [CNT_W-1:0]           dwell;
    logic                       sample_en;
    logic signed [AMP_W-1:0]    sample_out;
    logic                       sample_valid;
    logic [CNT_W-1:0]           point_idx;
    logic                       point_strobe;
    logic                       busy;
    logic                       done;

    modport master (
        output start, abort, f_start, f_step, n_points, dwell, sample_en,
        input  sample_out, sample_valid, point_idx, point_strobe, busy, done
    );

    modport slave (
        input  start, abort, f_start, f_step, n_points, dwell, sample_en,
        output sample_out, sample_valid, point_idx, point_strobe, busy, done
    );
endinterface

// File: rtl/ac_sweep_dds.sv
// Stepped-frequency sine sweep generator: phase-accumulator DDS with a quarter-wave
// LUT, a sweep FSM that steps the FCW per point, and a 2-stage sample pipeline.
module ac_sweep_dds #(
    parameter int PHASE_W = 24,
    parameter int LUT_AW  = 8,
    parameter int AMP_W   = 12,
    parameter int CNT_W   = 16
) (
    input logic           clk,
    input logic           rst_n,
    ac_sweep_dds_if.slave bus
);
    localparam int  LUT_N    = 1 << LUT_AW;
    localparam int  MAG_W    = AMP_W - 1;
    localparam int  LUT_BITS = LUT_N * MAG_W;
    localparam real PI       = 3.14159265358979323846;

    // Quarter-wave magnitudes sampled at bin centres (i+0.5) so the table has
    // no zero entry and odd-quadrant mirroring by address inversion is exact.
    function automatic logic [LUT_BITS-1:0] gen_lut();
        logic [LUT_BITS-1:0] v;
        real                 x;
        int                  m;
        v = '0;
        for (int i = 0; i < LUT_N; i++) begin
            x = ((2.0 ** (AMP_W - 1)) - 1.0) *
                $sin(2.0 * PI * (real'(i) + 0.5) / real'(4 * LUT_N));
            m = $rtoi(x + 0.5);
            v[i*MAG_W +: MAG_W] = m[MAG_W-1:0];
        end
        return v;
    endfunction

    localparam logic [LUT_BITS-1:0] LUT_TABLE = gen_lut();

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [PHASE_W-1:0]      r_phase;
    logic [PHASE_W-1:0]      r_fcw;
    logic [PHASE_W-1:0]      r_fstep;
    logic [CNT_W-1:0]        r_n_eff;
    logic [CNT_W-1:0]        r_dwell_eff;
    logic [CNT_W-1:0]        r_dwell_cnt;
    logic [CNT_W-1:0]        r_point_idx;
    logic                    r_point_strobe;
    logic                    r_done;
    logic                    r_busy;

    logic                    r_s1_valid;
    logic                    r_s1_neg;
    logic [LUT_AW-1:0]       r_s1_addr;
    logic signed [AMP_W-1:0] r_sample_out;
    logic                    r_sample_valid;

    logic                    w_launch;
    logic                    w_issue;
    logic                    w_advance;
    logic                    w_dwell_end;
    logic                    w_last_point;
    logic [1:0]              w_quad;
    logic [LUT_AW-1:0]       w_frac;
    logic [MAG_W-1:0]        w_lut_mag;
    logic signed [AMP_W-1:0] w_mag_ext;
    logic                    w_s1_valid_nxt;
    logic                    w_out_valid_nxt;

    assign w_dwell_end     = (r_dwell_cnt == (r_dwell_eff - CNT_W'(1)));
    assign w_last_point    = (r_point_idx == (r_n_eff - CNT_W'(1)));
    assign w_quad          = r_phase[PHASE_W-1 -: 2];
    assign w_frac          = r_phase[PHASE_W-3 -: LUT_AW];
    assign w_lut_mag       = LUT_TABLE[r_s1_addr*MAG_W +: MAG_W];
    assign w_mag_ext       = $signed({1'b0, w_lut_mag});
    assign w_s1_valid_nxt  = w_issue && !bus.abort;
    assign w_out_valid_nxt = r_s1_valid && !bus.abort;

    // Sweep FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sweep FSM next state and per-cycle control strobes; abort overrides start.
    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_issue     = 1'b0;
        w_advance   = 1'b0;
        if (bus.abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        w_launch    = 1'b1;
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_state_nxt = r_state;
                    end
                end
                ST_RUN: begin
                    if (bus.sample_en) begin
                        w_issue = 1'b1;
                        if (w_dwell_end && w_last_point) begin
                            w_state_nxt = ST_DONE;
                        end else if (w_dwell_end) begin
                            w_advance = 1'b1;
                        end else begin
                            w_advance = 1'b0;
                        end
                    end else begin
                        w_issue = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Sweep datapath: config latch at start, phase accumulation, dwell and point counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase        <= '0;
            r_fcw          <= '0;
            r_fstep        <= '0;
            r_n_eff        <= '0;
            r_dwell_eff    <= '0;
            r_dwell_cnt    <= '0;
            r_point_idx    <= '0;
            r_point_strobe <= 1'b0;
        end else begin
            r_point_strobe <= w_advance;
            if (w_launch) begin
                r_fcw       <= bus.f_start;
                r_fstep     <= bus.f_step;
                r_n_eff     <= (bus.n_points == '0) ? CNT_W'(1) : bus.n_points;
                r_dwell_eff <= (bus.dwell == '0) ? CNT_W'(1) : bus.dwell;
                r_phase     <= '0;
                r_dwell_cnt <= '0;
                r_point_idx <= '0;
            end else if (w_issue) begin
                // Phase keeps running across frequency steps; only the FCW changes.
                r_phase <= r_phase + r_fcw;
                if (w_advance) begin
                    r_point_idx <= r_point_idx + CNT_W'(1);
                    r_fcw       <= r_fcw + r_fstep;
                    r_dwell_cnt <= '0;
                end else begin
                    r_dwell_cnt <= r_dwell_cnt + CNT_W'(1);
                end
            end else begin
                r_phase <= r_phase;
            end
        end
    end

    // Stage 1: quadrant decode and mirrored LUT address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_neg   <= 1'b0;
            r_s1_addr  <= '0;
        end else begin
            r_s1_valid <= w_s1_valid_nxt;
            if (w_issue) begin
                r_s1_neg  <= w_quad[1];
                r_s1_addr <= w_quad[0] ? ~w_frac : w_frac;
            end else begin
                r_s1_neg  <= r_s1_neg;
            end
        end
    end

    // Stage 2: LUT read and sign; output returns to zero whenever no sample is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sample_out   <= '0;
            r_sample_valid <= 1'b0;
        end else if (!w_out_valid_nxt) begin
            r_sample_out   <= '0;
            r_sample_valid <= 1'b0;
        end else begin
            r_sample_out   <= r_s1_neg ? -w_mag_ext : w_mag_ext;
            r_sample_valid <= 1'b1;
        end
    end

    // Status flags, registered from next-cycle state so they align with the pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_done <= (w_state_nxt == ST_DONE);
            r_busy <= (w_state_nxt == ST_RUN) || w_s1_valid_nxt || w_out_valid_nxt;
        end
    end

    assign bus.sample_out   = r_sample_out;
    assign bus.sample_valid = r_sample_valid;
    assign bus.point_idx    = r_point_idx;
    assign bus.point_strobe = r_point_strobe;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
endmodule

// File: tb/tb_ac_sweep_dds.sv
// Directed self-checking bench for ac_sweep_dds: hand-computed LUT samples,
// point stepping, FCW wrap, zero-config handling, abort flush and async reset.
module tb_ac_sweep_dds;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Point 0: fcw 1u, point 1: 2u, point 2: 3u (u = 2^20); phase continues across steps
    int exp3 [15] = '{6, 789, 1452, 1894, 2047,
                      1889, 778, -789, -1894, -1889,
                      -778, 1452, 1889, -6, -1894};

    always #5 clk = ~clk;

    ac_sweep_dds_if #(.PHASE_W(24), .AMP_W(12), .CNT_W(16)) bus();

    ac_sweep_dds #(.PHASE_W(24), .LUT_AW(8), .AMP_W(12), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [23:0] fs, input logic [23:0] fst,
                          input logic [15:0] np, input logic [15:0] dw);
        bus.f_start  = fs;
        bus.f_step   = fst;
        bus.n_points = np;
        bus.dwell    = dw;
        bus.start    = 1'b1;
        step();
        bus.start    = 1'b0;
        chk("start_done_clr", bus.done, 0);
        chk("start_busy", bus.busy, 1);
    endtask

    // One sample_en pulse; checks no valid after 1 cycle, then the value after 2
    task automatic samp(input string tag, input longint exp_val,
                        input longint exp_idx, input longint exp_stb);
        bus.sample_en = 1'b1;
        step();
        bus.sample_en = 1'b0;
        chk({tag, ".lat1"}, bus.sample_valid, 0);
        chk({tag, ".idx"}, bus.point_idx, exp_idx);
        chk({tag, ".stb"}, bus.point_strobe, exp_stb);
        step();
        chk({tag, ".valid"}, bus.sample_valid, 1);
        chk({tag, ".val"}, bus.sample_out, exp_val);
        chk({tag, ".stb_off"}, bus.point_strobe, 0);
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.f_start  = 24'd0;
        bus.f_step   = 24'd0;
        bus.n_points = 16'd0;
        bus.dwell    = 16'd0;
        bus.sample_en = 1'b0;

        // Reset held with random inputs
        for (int i = 0; i < 6; i++) begin
            bus.start     = 1'($urandom);
            bus.abort     = 1'($urandom);
            bus.sample_en = 1'($urandom);
            bus.f_start   = 24'($urandom);
            bus.f_step    = 24'($urandom);
            bus.n_points  = 16'($urandom);
            bus.dwell     = 16'($urandom);
            step();
        end
        chk("rst.out", bus.sample_out, 0);
        chk("rst.valid", bus.sample_valid, 0);
        chk("rst.idx", bus.point_idx, 0);
        chk("rst.stb", bus.point_strobe, 0);
        chk("rst.busy", bus.busy, 0);
        chk("rst.done", bus.done, 0);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.sample_en = 1'b0;
        rst_n = 1'b1;
        step();

        // Idle: sample_en ignored
        for (int i = 0; i < 6; i++) begin
            bus.sample_en = ~bus.sample_en;
            step();
            chk("idle.valid", bus.sample_valid, 0);
            chk("idle.busy", bus.busy, 0);
        end
        bus.sample_en = 1'b0;

        // Single point, four quadrant samples
        launch(24'h40_0000, 24'h00_0000, 16'd1, 16'd4);
        samp("t2s0", 6, 0, 0);
        samp("t2s1", 2047, 0, 0);
        samp("t2s2", -6, 0, 0);
        samp("t2s3", -2047, 0, 0);
        chk("t2.drain_busy", bus.busy, 1);
        step();
        chk("t2.done", bus.done, 1);
        chk("t2.busy", bus.busy, 0);
        chk("t2.out0", bus.sample_out, 0);

        // Three points, dwell 5
        launch(24'h10_0000, 24'h10_0000, 16'd3, 16'd5);
        for (int i = 0; i < 15; i++) begin
            samp($sformatf("t3s%0d", i), exp3[i],
                 (i < 4) ? 0 : ((i < 9) ? 1 : 2),
                 (i == 4 || i == 9) ? 1 : 0);
            if (i < 14) chk($sformatf("t3s%0d.notdone", i), bus.done, 0);
        end
        step();
        chk("t3.done", bus.done, 1);
        chk("t3.busy", bus.busy, 0);
        chk("t3.idx", bus.point_idx, 2);

        // FCW wrap: 0xC00000 + 0x800000 -> 0x400000
        launch(24'hC0_0000, 24'h80_0000, 16'd2, 16'd2);
        samp("t4s0", 6, 0, 0);
        samp("t4s1", -2047, 1, 1);
        samp("t4s2", -6, 1, 0);
        samp("t4s3", -2047, 1, 0);
        step();
        chk("t4.done", bus.done, 1);

        // Zero points / zero dwell behave as one
        launch(24'h40_0000, 24'h00_0000, 16'd0, 16'd0);
        samp("t5s0", 6, 0, 0);
        step();
        chk("t5.done", bus.done, 1);
        chk("t5.busy", bus.busy, 0);
        bus.sample_en = 1'b1;
        step();
        bus.sample_en = 1'b0;
        step();
        chk("t5.extra_valid", bus.sample_valid, 0);

        // Abort with a sample in flight, simultaneous start
        launch(24'h40_0000, 24'h00_0000, 16'd2, 16'd5);
        samp("t6s0", 6, 0, 0);
        samp("t6s1", 2047, 0, 0);
        samp("t6s2", -6, 0, 0);
        bus.sample_en = 1'b1;
        step();
        bus.sample_en = 1'b0;
        bus.abort = 1'b1;
        bus.start = 1'b1;
        step();
        bus.abort = 1'b0;
        bus.start = 1'b0;
        chk("t6.valid", bus.sample_valid, 0);
        chk("t6.out", bus.sample_out, 0);
        chk("t6.done", bus.done, 0);
        chk("t6.busy", bus.busy, 0);
        for (int i = 0; i < 4; i++) begin
            bus.sample_en = ~bus.sample_en;
            step();
            chk("t6.post_valid", bus.sample_valid, 0);
            chk("t6.post_busy", bus.busy, 0);
        end
        bus.sample_en = 1'b0;

        // Asynchronous reset mid-sweep
        launch(24'h40_0000, 24'h00_0000, 16'd3, 16'd2);
        samp("t7s0", 6, 0, 0);
        samp("t7s1", 2047, 1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7.busy", bus.busy, 0);
        chk("t7.idx", bus.point_idx, 0);
        chk("t7.out", bus.sample_out, 0);
        rst_n = 1'b1;
        step();
        chk("t7.after_busy", bus.busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
